// File: rtl/mmu_rsp_merger_if.sv
// Bundle between the mmu_top response FIFO pop ports, the merged response stream and the
// page/failure counters. The slave view belongs to the merger; the master view drives it.
interface mmu_rsp_merger_if #(
  parameter int ID_W   = 13,
  parameter int PIDX_W = 15,
  parameter int SIZE_W = 4,
  parameter int FR_W   = 2,
  parameter int CNT_W  = 16
) ();
  logic              alloc_rsp_fifo_not_empty;
  logic              free_rsp_fifo_not_empty;
  logic              alloc_rsp_pop;
  logic              free_rsp_pop;
  logic [ID_W-1:0]   alloc_rsp_id;
  logic [PIDX_W-1:0] alloc_rsp_page_idx;
  logic              alloc_rsp_fail;
  logic [FR_W-1:0]   alloc_rsp_fail_reason;
  logic [SIZE_W-1:0] alloc_rsp_origin_size;
  logic [SIZE_W-1:0] alloc_rsp_actual_size;
  logic [ID_W-1:0]   free_rsp_id;
  logic              free_rsp_fail;
  logic [FR_W-1:0]   free_rsp_fail_reason;
  logic [SIZE_W-1:0] free_rsp_origin_size;
  logic [SIZE_W-1:0] free_rsp_actual_size;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_is_free;
  logic [ID_W-1:0]   rsp_id;
  logic [PIDX_W-1:0] rsp_page_idx;
  logic              rsp_fail;
  logic [FR_W-1:0]   rsp_fail_reason;
  logic [SIZE_W-1:0] rsp_origin_size;
  logic [SIZE_W-1:0] rsp_actual_size;
  logic [CNT_W-1:0]  pages_in_use;
  logic [CNT_W-1:0]  fail_cnt;

  modport slave (
    input  alloc_rsp_fifo_not_empty, free_rsp_fifo_not_empty,
    output alloc_rsp_pop, free_rsp_pop,
    input  alloc_rsp_id, alloc_rsp_page_idx, alloc_rsp_fail, alloc_rsp_fail_reason,
    input  alloc_rsp_origin_size, alloc_rsp_actual_size,
    input  free_rsp_id, free_rsp_fail, free_rsp_fail_reason,
    input  free_rsp_origin_size, free_rsp_actual_size,
    output rsp_valid, input rsp_ready,
    output rsp_is_free, rsp_id, rsp_page_idx, rsp_fail, rsp_fail_reason,
    output rsp_origin_size, rsp_actual_size, pages_in_use, fail_cnt
  );

  modport master (
    output alloc_rsp_fifo_not_empty, free_rsp_fifo_not_empty,
    input  alloc_rsp_pop, free_rsp_pop,
    output alloc_rsp_id, alloc_rsp_page_idx, alloc_rsp_fail, alloc_rsp_fail_reason,
    output alloc_rsp_origin_size, alloc_rsp_actual_size,
    output free_rsp_id, free_rsp_fail, free_rsp_fail_reason,
    output free_rsp_origin_size, free_rsp_actual_size,
    input  rsp_valid, output rsp_ready,
    input  rsp_is_free, rsp_id, rsp_page_idx, rsp_fail, rsp_fail_reason,
    input  rsp_origin_size, rsp_actual_size, pages_in_use, fail_cnt
  );
endinterface

// File: rtl/mmu_rsp_merger.sv
// Round-robin merge of the mmu_top alloc/free response FIFOs into one valid/ready stream,
// with running counts of pages in use and failed responses.
module mmu_rsp_merger #(
  parameter int ID_W   = 13,
  parameter int PIDX_W = 15,
  parameter int SIZE_W = 4,
  parameter int FR_W   = 2,
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              rst,
  mmu_rsp_merger_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, HOLD = 2'd2} state_t;

  state_t            state, state_nx;
  logic              sel_p0;
  logic              last_sel;
  logic              any_ne;
  logic              pick_free;
  logic              do_pop;
  logic              cap_fail;
  logic [SIZE_W-1:0] cap_act;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] sat_sub(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    return (a < b) ? '0 : a - b;
  endfunction

  // Alloc wins ties right after reset because last_sel starts on free.
  assign any_ne    = bus.alloc_rsp_fifo_not_empty | bus.free_rsp_fifo_not_empty;
  assign pick_free = bus.free_rsp_fifo_not_empty & (~bus.alloc_rsp_fifo_not_empty | ~last_sel);
  assign cap_fail  = sel_p0 ? bus.free_rsp_fail : bus.alloc_rsp_fail;
  assign cap_act   = sel_p0 ? bus.free_rsp_actual_size : bus.alloc_rsp_actual_size;

  always_comb begin
    state_nx = state;
    do_pop   = 1'b0;
    case (state)
      IDLE: begin
        if (any_ne) begin
          do_pop   = 1'b1;
          state_nx = WAIT;
        end
      end
      WAIT: state_nx = HOLD;
      HOLD: begin
        if (bus.rsp_valid && bus.rsp_ready) begin
          do_pop   = any_ne;
          state_nx = any_ne ? WAIT : IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    bus.alloc_rsp_pop = do_pop & ~pick_free;
    bus.free_rsp_pop  = do_pop & pick_free;
  end

  // Pop stage: remember the source; FIFO data becomes valid in WAIT, where it is captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      sel_p0              <= 1'b0;
      last_sel            <= 1'b1;
      bus.rsp_valid       <= 1'b0;
      bus.rsp_is_free     <= 1'b0;
      bus.rsp_id          <= '0;
      bus.rsp_page_idx    <= '0;
      bus.rsp_fail        <= 1'b0;
      bus.rsp_fail_reason <= '0;
      bus.rsp_origin_size <= '0;
      bus.rsp_actual_size <= '0;
      bus.pages_in_use    <= '0;
      bus.fail_cnt        <= '0;
    end else begin
      state <= state_nx;
      if (do_pop) sel_p0 <= pick_free;
      if (state == WAIT) begin
        bus.rsp_valid       <= 1'b1;
        last_sel            <= sel_p0;
        bus.rsp_is_free     <= sel_p0;
        bus.rsp_id          <= sel_p0 ? bus.free_rsp_id : bus.alloc_rsp_id;
        bus.rsp_page_idx    <= sel_p0 ? '0 : bus.alloc_rsp_page_idx;
        bus.rsp_fail        <= cap_fail;
        bus.rsp_fail_reason <= sel_p0 ? bus.free_rsp_fail_reason : bus.alloc_rsp_fail_reason;
        bus.rsp_origin_size <= sel_p0 ? bus.free_rsp_origin_size : bus.alloc_rsp_origin_size;
        bus.rsp_actual_size <= cap_act;
        if (cap_fail)
          bus.fail_cnt <= sat_add(bus.fail_cnt, CNT_W'(1));
        else if (sel_p0)
          bus.pages_in_use <= sat_sub(bus.pages_in_use, CNT_W'(cap_act));
        else
          bus.pages_in_use <= sat_add(bus.pages_in_use, CNT_W'(cap_act));
      end else if (state == HOLD && bus.rsp_valid && bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
      end
    end
  end
endmodule
